// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the D-stage hazard controller: Tuse/Tnew codes,
// mult/div instruction kinds, forwarding selects and the E/M shadow record.
package hazard_ctrl_pkg;

  localparam logic [2:0] TUSE_D    = 3'd0;
  localparam logic [2:0] TUSE_E    = 3'd1;
  localparam logic [2:0] TUSE_M    = 3'd2;
  localparam logic [2:0] TUSE_NONE = 3'd5;

  localparam logic [2:0] TNEW_ALU  = 3'd2;
  localparam logic [2:0] TNEW_LOAD = 3'd3;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;
  localparam logic [1:0] MD_MOVE = 2'b11;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // One in-flight writer as seen by the hazard logic.
  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } shadow_t;

  // Tnew shrinks by one per stage advanced and never goes below zero.
  function automatic logic [1:0] tnew_dec(input logic [2:0] t);
    return (t == 3'd0) ? 2'd0 : 2'(t - 3'd1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage request / hazard response bundle between the pipeline datapath
// (master) and the hazard controller (slave).
interface hazard_ctrl_if;

  logic [4:0] D_A1;
  logic [4:0] D_A2;
  logic [4:0] D_A3;
  logic [2:0] D_TUsers;
  logic [2:0] D_TUsert;
  logic [2:0] D_TNew;
  logic [1:0] D_md_kind;

  logic       stall;
  logic [1:0] fwd_rs_D;
  logic [1:0] fwd_rt_D;
  logic [4:0] E_A3;
  logic [1:0] E_TNew;
  logic [4:0] M_A3;
  logic [1:0] M_TNew;
  logic       md_busy;

  modport master (
    output D_A1, D_A2, D_A3, D_TUsers, D_TUsert, D_TNew, D_md_kind,
    input  stall, fwd_rs_D, fwd_rt_D, E_A3, E_TNew, M_A3, M_TNew, md_busy
  );

  modport slave (
    input  D_A1, D_A2, D_A3, D_TUsers, D_TUsert, D_TNew, D_md_kind,
    output stall, fwd_rs_D, fwd_rt_D, E_A3, E_TNew, M_A3, M_TNew, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Single-operand hazard compare: decides whether one D-stage source must
// stall and where its value should be forwarded from.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] a,
  input  logic [2:0] tuse,
  input  logic [4:0] e_a3,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_a3,
  input  logic [1:0] m_tnew,
  output logic       stall,
  output logic [1:0] fwd
);

  logic e_hit;
  logic m_hit;
  logic e_late;
  logic m_late;

  // $0 is hard-wired, so it never aliases an in-flight writer.
  assign e_hit  = (a != 5'd0) && (a == e_a3);
  assign m_hit  = (a != 5'd0) && (a == m_a3);
  assign e_late = tuse < {1'b0, e_tnew};
  assign m_late = tuse < {1'b0, m_tnew};

  assign stall = (tuse != TUSE_NONE) && ((e_hit && e_late) || (m_hit && m_late));

  // NOTE: default assigned first so every path drives fwd and no latch is inferred.
  always_comb begin
    fwd = FWD_RF;
    if (e_hit) begin
      // The younger writer in E shadows M even while its value is not ready.
      if (e_tnew == 2'd0) fwd = FWD_E;
    end else if (m_hit && (m_tnew == 2'd0)) begin
      fwd = FWD_M;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E/M writer shadows, per-operand stall and
// forward selection, and mult/div unit occupancy tracking.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  shadow_t    e_q;
  shadow_t    m_q;
  shadow_t    e_next;
  logic [3:0] md_cnt;
  logic       stall_s;
  logic       stall_t;
  logic       md_busy;
  logic       md_stall;
  logic       stall;

  hazard_cmp u_cmp_rs (
    .a      (bus.D_A1),
    .tuse   (bus.D_TUsers),
    .e_a3   (e_q.a3),
    .e_tnew (e_q.tnew),
    .m_a3   (m_q.a3),
    .m_tnew (m_q.tnew),
    .stall  (stall_s),
    .fwd    (bus.fwd_rs_D)
  );

  hazard_cmp u_cmp_rt (
    .a      (bus.D_A2),
    .tuse   (bus.D_TUsert),
    .e_a3   (e_q.a3),
    .e_tnew (e_q.tnew),
    .m_a3   (m_q.a3),
    .m_tnew (m_q.tnew),
    .stall  (stall_t),
    .fwd    (bus.fwd_rt_D)
  );

  assign md_busy  = (md_cnt != 4'd0);
  assign md_stall = (bus.D_md_kind != MD_NONE) && md_busy;
  assign stall    = stall_s | stall_t | md_stall;

  // A stalled D instruction stays put, so E receives a bubble instead.
  assign e_next = stall ? '0 : '{a3: bus.D_A3, tnew: tnew_dec(bus.D_TNew)};

  // NOTE: sequential state uses non-blocking assignments so M captures the old E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_next;
      m_q <= '{a3: e_q.a3, tnew: tnew_dec({1'b0, e_q.tnew})};
    end
  end

  // Loading only happens when the mult/div actually leaves D; a mult/div
  // held in D while the unit is busy is already covered by md_stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= 4'd0;
    end else if (!stall && (bus.D_md_kind == MD_MULT)) begin
      md_cnt <= MULT_LOAD;
    end else if (!stall && (bus.D_md_kind == MD_DIV)) begin
      md_cnt <= DIV_LOAD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  assign bus.stall   = stall;
  assign bus.E_A3    = e_q.a3;
  assign bus.E_TNew  = e_q.tnew;
  assign bus.M_A3    = m_q.a3;
  assign bus.M_TNew  = m_q.tnew;
  assign bus.md_busy = md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-indexed model of issued writers
// predicts each cycle's response; a separate monitor compares.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a3;
    int tnew;
  } wr_t;

  typedef struct {
    int stall;
    int fwd_rs;
    int fwd_rt;
    int e_a3;
    int e_tnew;
    int m_a3;
    int m_tnew;
    int md_busy;
  } exp_t;

  wr_t  writers[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   md_last = -1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Writer that left D at cycle c; bubble when nothing issued then.
  function automatic void writer_at(input int c, output int a3, output int tnew);
    a3 = 0;
    tnew = 0;
    foreach (writers[i]) if (writers[i].cyc == c) begin
      a3   = writers[i].a3;
      tnew = writers[i].tnew;
    end
  endfunction

  function automatic int left(input int tnew, input int age);
    return (tnew - age > 0) ? tnew - age : 0;
  endfunction

  function automatic int must_wait(input int a, input int tuse, input int ea, input int er,
                                   input int ma, input int mr);
    if (a == 0) return 0;
    return int'((a == ea && tuse < er) || (a == ma && tuse < mr));
  endfunction

  // Youngest matching writer wins; it supplies the value only if ready.
  function automatic int source(input int a, input int ea, input int er, input int ma,
                                input int mr);
    if (a == 0) return int'(FWD_RF);
    if (a == ea) return (er == 0) ? int'(FWD_E) : int'(FWD_RF);
    if (a == ma && mr == 0) return int'(FWD_M);
    return int'(FWD_RF);
  endfunction

  task automatic step(input int a1, input int a2, input int a3, input int tus,
                      input int tut, input int tnew, input int kind);
    exp_t e;
    int ea, et, ma, mt, er, mr, md_st;
    @(negedge clk);
    bus.D_A1      = 5'(a1);
    bus.D_A2      = 5'(a2);
    bus.D_A3      = 5'(a3);
    bus.D_TUsers  = 3'(tus);
    bus.D_TUsert  = 3'(tut);
    bus.D_TNew    = 3'(tnew);
    bus.D_md_kind = 2'(kind);
    writer_at(cyc - 1, ea, et);
    writer_at(cyc - 2, ma, mt);
    er = left(et, 1);
    mr = left(mt, 2);
    e.md_busy = int'(cyc <= md_last);
    md_st     = int'(kind != 0 && e.md_busy != 0);
    e.stall   = must_wait(a1, tus, ea, er, ma, mr) | must_wait(a2, tut, ea, er, ma, mr) | md_st;
    e.fwd_rs  = source(a1, ea, er, ma, mr);
    e.fwd_rt  = source(a2, ea, er, ma, mr);
    e.e_a3    = ea;
    e.e_tnew  = er;
    e.m_a3    = ma;
    e.m_tnew  = mr;
    sb.push_back(e);
    if (e.stall == 0) begin
      writers.push_back('{cyc: cyc, a3: a3, tnew: tnew});
      if (kind == int'(MD_MULT)) md_last = cyc + MULT_N;
      if (kind == int'(MD_DIV))  md_last = cyc + DIV_N;
    end
    while (writers.size() > 0 && writers[0].cyc < cyc - 2) void'(writers.pop_front());
    cyc++;
  endtask

  task automatic nop();
    step(0, 0, 0, int'(TUSE_NONE), int'(TUSE_NONE), 0, int'(MD_NONE));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stall"},   int'(bus.stall),    0);
    check({tag, "_fwd_rs"},  int'(bus.fwd_rs_D), 0);
    check({tag, "_fwd_rt"},  int'(bus.fwd_rt_D), 0);
    check({tag, "_e_a3"},    int'(bus.E_A3),     0);
    check({tag, "_e_tnew"},  int'(bus.E_TNew),   0);
    check({tag, "_m_a3"},    int'(bus.M_A3),     0);
    check({tag, "_m_tnew"},  int'(bus.M_TNew),   0);
    check({tag, "_md_busy"}, int'(bus.md_busy),  0);
  endtask

  // Asserted mid-cycle after the monitor sampled; effects must show before the edge.
  task automatic mid_reset();
    #3 reset = 1'b0;
    #1 check_idle("async_rst");
    @(posedge clk);
    #1 reset = 1'b1;
    writers.delete();
    md_last = -1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall",    int'(bus.stall),    e.stall);
        check("fwd_rs_D", int'(bus.fwd_rs_D), e.fwd_rs);
        check("fwd_rt_D", int'(bus.fwd_rt_D), e.fwd_rt);
        check("E_A3",     int'(bus.E_A3),     e.e_a3);
        check("E_TNew",   int'(bus.E_TNew),   e.e_tnew);
        check("M_A3",     int'(bus.M_A3),     e.m_a3);
        check("M_TNew",   int'(bus.M_TNew),   e.m_tnew);
        check("md_busy",  int'(bus.md_busy),  e.md_busy);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int tu_tab[4];
    int tn_tab[3];
    int r;
    tu_tab = '{int'(TUSE_D), int'(TUSE_E), int'(TUSE_M), int'(TUSE_NONE)};
    tn_tab = '{0, int'(TNEW_ALU), int'(TNEW_LOAD)};

    reset         = 1'b0;
    bus.D_A1      = '0;
    bus.D_A2      = '0;
    bus.D_A3      = '0;
    bus.D_TUsers  = TUSE_NONE;
    bus.D_TUsert  = TUSE_NONE;
    bus.D_TNew    = '0;
    bus.D_md_kind = MD_NONE;
    #2 check_idle("reset");
    @(posedge clk);
    #1 reset = 1'b1;

    // load-use: lw $1 then addu rs=$1 (Tuse E)
    step(0, 0, 1, 5, 5, 3, 0);
    step(1, 0, 4, 1, 5, 2, 0);
    step(1, 0, 4, 1, 5, 2, 0);
    nop(); nop();
    // ALU then branch: addu $2 then beq rs=$2 (Tuse D)
    step(0, 0, 2, 5, 5, 2, 0);
    step(2, 0, 0, 0, 5, 0, 0);
    step(2, 0, 0, 0, 5, 0, 0);
    nop(); nop();
    // lw $3 then sw rt=$3 (Tuse M)
    step(0, 0, 3, 5, 5, 3, 0);
    step(0, 3, 0, 1, 2, 0, 0);
    nop(); nop();
    // writer to $0 then reader of $0 with Tuse D
    step(0, 0, 0, 5, 5, 3, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    nop(); nop();
    // mult then mflo, div then mflo
    step(0, 0, 0, 5, 5, 0, 1);
    repeat (MULT_N + 1) step(0, 0, 5, 5, 5, 2, 3);
    step(0, 0, 0, 5, 5, 0, 2);
    repeat (DIV_N + 1) step(0, 0, 5, 5, 5, 2, 3);
    nop(); nop();
    // div, reset during busy cycle 4 with mfhi waiting, mfhi then proceeds
    step(0, 0, 0, 5, 5, 0, 2);
    nop(); nop(); nop();
    step(0, 0, 6, 5, 5, 2, 3);
    mid_reset();
    step(0, 0, 6, 5, 5, 2, 3);
    nop(); nop();

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           tu_tab[$urandom_range(0, 3)], tu_tab[$urandom_range(0, 3)],
           tn_tab[$urandom_range(0, 2)], (r < 7) ? 0 : r - 6);
      if ($urandom_range(0, 149) == 0) mid_reset();
    end

    repeat (3) @(negedge clk);
    #3 check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
